axi_sram_bridge: RTL and testbench
==================================

// Module: axi_sram_bridge
// PURPOSE
//  AXI3 slave that terminates the CPU core's external master port (ar/r/aw/w/b channels)
//  and drives one single-ported synchronous word SRAM. It is the memory-side stage that
//  consumes what the core top and its AXI arbiter emit, for simulation and FPGA bring-up.
//  One transaction in flight at a time. Reads have priority over writes.
// PARAMETERS
//  ID_W    4   width of arid/rid/awid/bid
//  RAM_AW  16  SRAM word-address width; SRAM holds 2**RAM_AW 32-bit words
// PORTS
//  aclk       in   1       clock; everything samples on posedge
//  aresetn    in   1       asynchronous active-low reset
//  arid       in   ID_W    read ID
//  araddr     in   32      read byte address
//  arlen      in   4       read beats minus 1
//  arsize     in   3       log2 bytes per beat, 0..2
//  arburst    in   2       00 FIXED, 01 INCR, 10 WRAP
//  arvalid    in   1       read address valid
//  arready    out  1       read address accepted
//  rid        out  ID_W    ID of the read burst
//  rdata      out  32      read data
//  rresp      out  2       00 OKAY, 10 SLVERR
//  rlast      out  1       last read beat
//  rvalid     out  1       read data valid
//  rready     in   1       master accepts the read beat
//  awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_W/32/4/3/2/1  write address (as ar*)
//  awready    out  1       write address accepted
//  wdata      in   32      write data
//  wstrb      in   4       byte write enables
//  wlast      in   1       master's last write beat
//  wvalid     in   1       write data valid
//  wready     out  1       write data accepted
//  bid        out  ID_W    write response ID
//  bresp      out  2       write response
//  bvalid     out  1       write response valid
//  bready     in   1       master accepts the write response
//  ram_en     out  1       SRAM access strobe
//  ram_we     out  4       SRAM byte write enables; 0 means read
//  ram_addr   out  RAM_AW  SRAM word address = cur_addr[RAM_AW+1:2]
//  ram_wdata  out  32      SRAM write data
//  ram_rdata  in   32      SRAM read data, valid 1 cycle after ram_en with ram_we=0
// BEHAVIOUR
//  States: IDLE, RD_REQ, RD_WAIT, RD_DATA, WR_DATA, WR_RESP.
//  Reset (async) puts the FSM in IDLE. All outputs are 0, except arready=1 and
//   awready=!arvalid, which come from IDLE.
//  Reset mid-burst abandons the burst. No partial response is issued after reset.
//  Protocol: a valid never drops without its handshake. Payload is stable while valid is high.
//  IDLE:
//   arready=1. awready=!arvalid. This is the read-priority rule.
//   On ar handshake: latch id/addr/len/size/burst, clear beat cnt, go to RD_REQ.
//   Otherwise, on aw handshake: latch the aw fields, clear cnt, go to WR_DATA.
//  RD_REQ: ram_en=1, ram_we=0. Always go to RD_WAIT next cycle.
//  RD_WAIT: capture ram_rdata into the rdata register. Go to RD_DATA.
//  RD_DATA:
//   rvalid=1. rlast=(cnt==len). rid is the latched id.
//   rdata/rresp/rlast are held stable until rready.
//   On handshake: if last, go to IDLE; else advance the address, cnt++, go to RD_REQ.
//   Throughput is 1 beat per 3 cycles minimum.
//  WR_DATA:
//   wready=1. On w handshake: ram_en=1, ram_we=wstrb, ram_wdata=wdata, at the current address.
//   When cnt==len, go to WR_RESP; else advance the address, cnt++.
//   Beat count alone ends the burst; wlast does not.
//   Set a sticky error flag if wlast is 1 on any non-final beat, or 0 on the final beat.
//  WR_RESP:
//   bvalid=1. bid is the latched id. bresp=10 if the error flag is set, else 00.
//   On bready, clear the flag and go to IDLE.
//  Address advance:
//   INCR: addr += (1<<size), 32-bit, wraps at 2**32.
//   FIXED: addr is unchanged.
//   WRAP or burst=11: unsupported. Every beat gets resp SLVERR and ram_en is held 0.
//    Reads return rdata=0.
//  arsize/awsize > 2: treated as unsupported exactly like WRAP.
//  Address range: ram_addr is truncated to RAM_AW bits, so accesses alias modulo the SRAM size.
//  Simultaneous arvalid and awvalid in IDLE: the read wins.
//   awready stays 0 that cycle. The write is accepted on the next visit to IDLE.
//  rresp is 00 for supported bursts.
//  The W channel is never accepted before its AW (wready=0 outside WR_DATA).
// TESTING
//  Single read: AR addr=0x10, len=0, INCR, ram[4]=0xDEADBEEF
//   -> rdata=0xDEADBEEF, rresp=00, rlast=1, rid=arid, 3 cycles after the ar handshake.
//  4-beat INCR write: awaddr=0x100, wstrb=F, data 1..4, wlast on beat 4
//   -> ram[0x40..0x43]=1..4; bresp=00, bid=awid.
//  Byte strobe: preload ram[0]=0x11223344, write wstrb=0010 wdata=0xAABBCCDD
//   -> ram[0]=0x1122CC44.
//  Priority: assert arvalid and awvalid in the same cycle
//   -> read completes first; awready=0 during it; the write then completes correctly.
//  Backpressure and errors:
//   - rready held low 5 cycles mid-burst -> rdata/rlast stable.
//   - wlast early on beat 2 of len=3 -> all 4 beats written, bresp=10.
//   - WRAP read -> rresp=10, rdata=0.
//  Reset mid-burst: deassert aresetn during beat 2 of a len=7 read
//   -> rvalid=0 at once, FIXED IDLE; a new read then returns correct data.

Source files
------------

// File: rtl/axi_sram_bridge.sv
// AXI3 slave bridging the core's external master port onto one single-ported word SRAM.
// One burst in flight; reads win over writes when both address channels are valid in IDLE.
module axi_sram_bridge #(
    parameter int ID_W   = 4,
    parameter int RAM_AW = 16
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [3:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,

    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,

    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [3:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,

    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,

    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,

    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        size_q, size_d;
    logic              fixed_q, fixed_d;
    logic              unsup_q, unsup_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              bvalid_q, bvalid_d;
    logic              arready_q, arready_d;
    logic              wready_q, wready_d;

    logic              last_beat;
    logic              wr_fire;
    logic              wr_mem;
    logic [31:0]       addr_next;

    assign last_beat = (cnt_q == len_q);
    assign wr_fire   = (state_q == WR_DATA) && wvalid;
    assign wr_mem    = wr_fire && !unsup_q;
    assign addr_next = fixed_q ? addr_q : (addr_q + (32'd1 << size_q));

    // WRAP, the reserved burst code and beats wider than the 32-bit bus are all refused.
    function automatic logic is_unsup(input logic [1:0] burst, input logic [2:0] size);
        return burst[1] || (size > 3'd2);
    endfunction

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        fixed_d   = fixed_q;
        unsup_d   = unsup_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        bresp_d   = bresp_q;

        case (state_q)
            IDLE: begin
                if (arvalid) begin
                    id_d    = arid;
                    addr_d  = araddr;
                    len_d   = arlen;
                    size_d  = arsize;
                    fixed_d = (arburst == 2'b00);
                    unsup_d = is_unsup(arburst, arsize);
                    cnt_d   = 4'd0;
                    state_d = RD_REQ;
                end else if (awvalid) begin
                    id_d    = awid;
                    addr_d  = awaddr;
                    len_d   = awlen;
                    size_d  = awsize;
                    fixed_d = (awburst == 2'b00);
                    unsup_d = is_unsup(awburst, awsize);
                    err_d   = err_q | is_unsup(awburst, awsize);
                    cnt_d   = 4'd0;
                    state_d = WR_DATA;
                end
            end
            RD_REQ: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                rdata_d = unsup_q ? 32'd0 : ram_rdata;
                rresp_d = unsup_q ? RESP_SLVERR : RESP_OKAY;
                rlast_d = last_beat;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (rready) begin
                    if (rlast_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_next;
                        cnt_d   = cnt_q + 4'd1;
                        state_d = RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                if (wvalid) begin
                    // The beat count terminates the burst; a misplaced wlast only poisons the response.
                    err_d = err_q | (wlast != last_beat);
                    if (last_beat) begin
                        bresp_d = err_d ? RESP_SLVERR : RESP_OKAY;
                        state_d = WR_RESP;
                    end else begin
                        addr_d = addr_next;
                        cnt_d  = cnt_q + 4'd1;
                    end
                end
            end
            WR_RESP: begin
                if (bready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        arready_d = (state_d == IDLE);
        wready_d  = (state_d == WR_DATA);
        rvalid_d  = (state_d == RD_DATA);
        bvalid_d  = (state_d == WR_RESP);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            fixed_q   <= 1'b0;
            unsup_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= '0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            wready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            fixed_q   <= fixed_d;
            unsup_q   <= unsup_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rvalid_q  <= rvalid_d;
            bresp_q   <= bresp_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            wready_q  <= wready_d;
        end
    end

    assign arready   = arready_q;
    assign awready   = arready_q && !arvalid;
    assign wready    = wready_q;

    assign rid       = id_q;
    assign rdata     = rdata_q;
    assign rresp     = rresp_q;
    assign rlast     = rlast_q;
    assign rvalid    = rvalid_q;

    assign bid       = id_q;
    assign bresp     = bresp_q;
    assign bvalid    = bvalid_q;

    // Write beats go straight to the SRAM in their handshake cycle; reads are issued from RD_REQ.
    assign ram_en    = ((state_q == RD_REQ) && !unsup_q) || wr_mem;
    assign ram_we    = wr_mem ? wstrb : 4'b0000;
    assign ram_addr  = addr_q[RAM_AW+1:2];
    assign ram_wdata = wr_mem ? wdata : 32'd0;

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Self-checking bench for axi_sram_bridge: directed scenarios followed by random bursts,
// all checked against a word-array memory model driven by the AXI burst rules.
module tb_axi_sram_bridge;

    localparam int ID_W    = 4;
    localparam int RAM_AW  = 16;
    localparam int NWORDS  = 1 << RAM_AW;
    localparam int TIMEOUT = 30;

    logic              aclk    = 1'b0;
    logic              aresetn = 1'b0;
    logic [ID_W-1:0]   arid    = '0;
    logic [31:0]       araddr  = '0;
    logic [3:0]        arlen   = '0;
    logic [2:0]        arsize  = '0;
    logic [1:0]        arburst = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready  = 1'b0;
    logic [ID_W-1:0]   awid    = '0;
    logic [31:0]       awaddr  = '0;
    logic [3:0]        awlen   = '0;
    logic [2:0]        awsize  = '0;
    logic [1:0]        awburst = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [31:0]       wdata   = '0;
    logic [3:0]        wstrb   = '0;
    logic              wlast   = 1'b0;
    logic              wvalid  = 1'b0;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready  = 1'b0;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic [31:0]       sram     [NWORDS];
    logic [31:0]       modelMem [NWORDS];
    logic [31:0]       wrData   [16];
    logic [3:0]        wrStrb   [16];
    int                ramEnCount = 0;
    int                nChecks    = 0;
    int                nErrors    = 0;

    axi_sram_bridge #(.ID_W(ID_W), .RAM_AW(RAM_AW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Free-running 100 MHz clock
    always #5 aclk = ~aclk;

    function automatic logic [31:0] fillWord(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit unsupported(input logic [1:0] burst, input logic [2:0] size);
        return (burst == 2'b10) || (burst == 2'b11) || (size > 3'd2);
    endfunction

    function automatic logic [31:0] beatAddr(input logic [31:0] addr, input int i,
                                             input logic [2:0] size, input logic [1:0] burst);
        if (burst == 2'b00) return addr;
        return addr + 32'(i) * (32'd1 << size);
    endfunction

    function automatic logic [RAM_AW-1:0] wordIdx(input logic [31:0] a);
        return a[RAM_AW+1:2];
    endfunction

    // Behavioural single-port SRAM: one-cycle read latency, byte-masked writes
    initial begin : sramModel
        logic [31:0] tmp;
        for (int i = 0; i < NWORDS; i++) sram[i] = fillWord(i);
        ram_rdata = '0;
        forever begin
            @(posedge aclk);
            if (ram_en) begin
                ramEnCount++;
                if (ram_we == 4'b0000) begin
                    ram_rdata <= sram[ram_addr];
                end else begin
                    tmp = sram[ram_addr];
                    for (int b = 0; b < 4; b++)
                        if (ram_we[b]) tmp[8*b +: 8] = ram_wdata[8*b +: 8];
                    sram[ram_addr] <= tmp;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sendAr(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        bit ok = 1'b0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        while (!ok && n < TIMEOUT) begin
            @(negedge aclk); ok = arready;
            @(posedge aclk); #1; n++;
        end
        arvalid = 1'b0;
        checkOutput("ar_accept", 32'(ok), 32'd1);
    endtask

    task automatic sendAw(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        bit ok = 1'b0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (!ok && n < TIMEOUT) begin
            @(negedge aclk); ok = awready;
            @(posedge aclk); #1; n++;
        end
        awvalid = 1'b0;
        checkOutput("aw_accept", 32'(ok), 32'd1);
    endtask

    task automatic readBeats(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int nBeats,
                             input int holdBeat, input int holdCycles, input bit randBp);
        logic [31:0] expData;
        logic [1:0]  expResp;
        bit          expLast;
        bit          bad;
        int          n;
        int          hold;
        bad = unsupported(burst, size);
        for (int i = 0; i < nBeats; i++) begin
            expData = bad ? 32'd0 : modelMem[wordIdx(beatAddr(addr, i, size, burst))];
            expResp = bad ? 2'b10 : 2'b00;
            expLast = (i == int'(len));
            n = 0;
            @(negedge aclk);
            while (!rvalid && n < TIMEOUT) begin @(negedge aclk); n++; end
            checkOutput("r_valid", 32'(rvalid), 32'd1);
            if (!rvalid) return;
            hold = (i == holdBeat) ? holdCycles : (randBp ? int'($urandom_range(0, 2)) : 0);
            for (int k = 0; k < hold; k++) begin
                checkOutput("r_hold_data", rdata, expData);
                checkOutput("r_hold_last", 32'(rlast), 32'(expLast));
                @(negedge aclk);
            end
            rready = 1'b1;
            checkOutput("r_valid_held", 32'(rvalid), 32'd1);
            checkOutput("r_data", rdata, expData);
            checkOutput("r_resp", 32'(rresp), 32'(expResp));
            checkOutput("r_last", 32'(rlast), 32'(expLast));
            checkOutput("r_id", 32'(rid), 32'(id));
            @(posedge aclk); #1;
            rready = 1'b0;
        end
    endtask

    task automatic waitB(input logic [ID_W-1:0] id, input logic [1:0] resp, input bit randBp);
        int n = 0;
        @(negedge aclk);
        while (!bvalid && n < TIMEOUT) begin @(negedge aclk); n++; end
        checkOutput("b_valid", 32'(bvalid), 32'd1);
        if (!bvalid) return;
        if (randBp) repeat ($urandom_range(0, 3)) @(negedge aclk);
        checkOutput("b_id", 32'(bid), 32'(id));
        checkOutput("b_resp", 32'(bresp), 32'(resp));
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    // Whole transaction; write data comes from wrData/wrStrb, wlast is inverted on beat earlyBeat
    task automatic applyStimulus(input bit isWrite, input logic [ID_W-1:0] id, input logic [31:0] addr,
                                 input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                                 input int earlyBeat, input int holdBeat, input int holdCycles,
                                 input bit randBp);
        bit          bad;
        bit          ok;
        int          n;
        int          lenI;
        logic [31:0] w;
        logic [RAM_AW-1:0] idx;
        lenI = int'(len);
        bad  = unsupported(burst, size);
        if (!isWrite) begin
            sendAr(id, addr, len, size, burst);
            readBeats(id, addr, len, size, burst, lenI + 1, holdBeat, holdCycles, randBp);
        end else begin
            sendAw(id, addr, len, size, burst);
            for (int i = 0; i <= lenI; i++) begin
                if (randBp) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
                wvalid = 1'b1;
                wdata  = wrData[i];
                wstrb  = wrStrb[i];
                wlast  = (i == lenI) ^ (i == earlyBeat);
                if (wlast != (i == lenI)) bad = 1'b1;
                n = 0;
                ok = 1'b0;
                while (!ok && n < TIMEOUT) begin
                    @(negedge aclk); ok = wready;
                    @(posedge aclk); #1; n++;
                end
                wvalid = 1'b0;
                wlast  = 1'b0;
                checkOutput("w_accept", 32'(ok), 32'd1);
                if (!ok) return;
                if (!unsupported(burst, size)) begin
                    idx = wordIdx(beatAddr(addr, i, size, burst));
                    w = modelMem[idx];
                    for (int b = 0; b < 4; b++)
                        if (wrStrb[i][b]) w[8*b +: 8] = wrData[i][8*b +: 8];
                    modelMem[idx] = w;
                end
            end
            waitB(id, bad ? 2'b10 : 2'b00, randBp);
        end
    endtask

    // Directed scenarios first, then a random mix, then a sweep of the busy SRAM region
    initial begin : stimulus
        int          lat;
        int          n;
        int          c0;
        int          early;
        int unsigned sel;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [ID_W-1:0] id;

        for (int i = 0; i < NWORDS; i++) modelMem[i] = fillWord(i);

        $display("[TB] reset values");
        repeat (3) @(negedge aclk);
        checkOutput("rst_arready", 32'(arready), 32'd1);
        checkOutput("rst_awready", 32'(awready), 32'd1);
        checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rst_wready", 32'(wready), 32'd0);
        checkOutput("rst_bvalid", 32'(bvalid), 32'd0);
        checkOutput("rst_ram_en", 32'(ram_en), 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        $display("[TB] single read");
        wrData[0] = 32'hDEAD_BEEF; wrStrb[0] = 4'hF;
        applyStimulus(1'b1, 4'h1, 32'h10, 4'd0, 3'd2, 2'b01, -1, -1, 0, 1'b0);
        checkOutput("preload_ram4", sram[4], 32'hDEAD_BEEF);
        sendAr(4'h6, 32'h10, 4'd0, 3'd2, 2'b01);
        lat = 1;
        @(negedge aclk);
        while (!rvalid && lat < TIMEOUT) begin @(posedge aclk); lat++; @(negedge aclk); end
        checkOutput("rd_latency", 32'(lat), 32'd3);
        checkOutput("rd_single_data", rdata, 32'hDEAD_BEEF);
        readBeats(4'h6, 32'h10, 4'd0, 3'd2, 2'b01, 1, -1, 0, 1'b0);

        $display("[TB] four-beat INCR write");
        for (int i = 0; i < 4; i++) begin wrData[i] = 32'(i + 1); wrStrb[i] = 4'hF; end
        applyStimulus(1'b1, 4'hA, 32'h100, 4'd3, 3'd2, 2'b01, -1, -1, 0, 1'b0);
        for (int i = 0; i < 4; i++) checkOutput("incr_wr_mem", sram[16'h40 + i], 32'(i + 1));

        $display("[TB] byte strobe");
        wrData[0] = 32'h1122_3344; wrStrb[0] = 4'hF;
        applyStimulus(1'b1, 4'h2, 32'h0, 4'd0, 3'd2, 2'b01, -1, -1, 0, 1'b0);
        wrData[0] = 32'hAABB_CCDD; wrStrb[0] = 4'b0010;
        applyStimulus(1'b1, 4'h3, 32'h0, 4'd0, 3'd2, 2'b01, -1, -1, 0, 1'b0);
        checkOutput("strobe_mem", sram[0], 32'h1122_CC44);

        $display("[TB] read priority");
        arid = 4'h7; araddr = 32'h100; arlen = 4'd1; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        awid = 4'hC; awaddr = 32'h300; awlen = 4'd1; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        @(negedge aclk);
        checkOutput("prio_arready", 32'(arready), 32'd1);
        checkOutput("prio_awready_same", 32'(awready), 32'd0);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        @(negedge aclk);
        checkOutput("prio_awready_busy", 32'(awready), 32'd0);
        checkOutput("prio_arready_busy", 32'(arready), 32'd0);
        readBeats(4'h7, 32'h100, 4'd1, 3'd2, 2'b01, 2, -1, 0, 1'b0);
        wrData[0] = 32'hCAFE_0001; wrData[1] = 32'hCAFE_0002; wrStrb[0] = 4'hF; wrStrb[1] = 4'hF;
        applyStimulus(1'b1, 4'hC, 32'h300, 4'd1, 3'd2, 2'b01, -1, -1, 0, 1'b0);
        checkOutput("prio_wr_mem0", sram[16'hC0], 32'hCAFE_0001);
        checkOutput("prio_wr_mem1", sram[16'hC1], 32'hCAFE_0002);

        $display("[TB] rready backpressure");
        applyStimulus(1'b0, 4'h4, 32'h100, 4'd3, 3'd2, 2'b01, -1, 1, 5, 1'b0);

        $display("[TB] early wlast");
        for (int i = 0; i < 4; i++) begin wrData[i] = 32'hB000_0000 + 32'(i); wrStrb[i] = 4'hF; end
        applyStimulus(1'b1, 4'h5, 32'h200, 4'd3, 3'd2, 2'b01, 1, -1, 0, 1'b0);
        for (int i = 0; i < 4; i++) checkOutput("early_wlast_mem", sram[16'h80 + i], 32'hB000_0000 + 32'(i));

        $display("[TB] unsupported bursts");
        c0 = ramEnCount;
        applyStimulus(1'b0, 4'h8, 32'h100, 4'd1, 3'd2, 2'b10, -1, -1, 0, 1'b0);
        wrData[0] = 32'h0BAD_0BAD; wrStrb[0] = 4'hF;
        applyStimulus(1'b1, 4'h9, 32'h100, 4'd0, 3'd2, 2'b10, -1, -1, 0, 1'b0);
        applyStimulus(1'b0, 4'hB, 32'h100, 4'd0, 3'd3, 2'b01, -1, -1, 0, 1'b0);
        checkOutput("unsup_no_ram", 32'(ramEnCount), 32'(c0));
        checkOutput("unsup_wr_mem", sram[16'h40], 32'd1);

        $display("[TB] FIXED read and address wrap");
        applyStimulus(1'b0, 4'hD, 32'h104, 4'd2, 3'd2, 2'b00, -1, -1, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin wrData[i] = $urandom(); wrStrb[i] = 4'hF; end
        applyStimulus(1'b1, 4'hE, 32'hFFFF_FFF8, 4'd3, 3'd2, 2'b01, -1, -1, 0, 1'b0);
        applyStimulus(1'b0, 4'hE, 32'hFFFF_FFF8, 4'd3, 3'd2, 2'b01, -1, -1, 0, 1'b0);

        $display("[TB] reset mid-burst");
        sendAr(4'h9, 32'h100, 4'd7, 3'd2, 2'b01);
        readBeats(4'h9, 32'h100, 4'd7, 3'd2, 2'b01, 1, -1, 0, 1'b0);
        n = 0;
        @(negedge aclk);
        while (!rvalid && n < TIMEOUT) begin @(negedge aclk); n++; end
        checkOutput("rst_mid_beat2", 32'(rvalid), 32'd1);
        aresetn = 1'b0;
        #1;
        checkOutput("rst_mid_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rst_mid_arready", 32'(arready), 32'd1);
        checkOutput("rst_mid_awready", 32'(awready), 32'd1);
        checkOutput("rst_mid_ram_en", 32'(ram_en), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        applyStimulus(1'b0, 4'h3, 32'h104, 4'd1, 3'd2, 2'b01, -1, -1, 0, 1'b0);

        $display("[TB] random transactions");
        for (int t = 0; t < 40; t++) begin
            addr  = $urandom() & 32'hFFF0_00FF;
            len   = 4'($urandom_range(0, 7));
            id    = 4'($urandom_range(0, 15));
            sel   = $urandom_range(0, 9);
            size  = (sel <= 5) ? 3'd2 : (sel == 6) ? 3'd1 : (sel == 7) ? 3'd0 : 3'd3;
            sel   = $urandom_range(0, 9);
            burst = (sel <= 5) ? 2'b01 : (sel <= 7) ? 2'b00 : (sel == 8) ? 2'b10 : 2'b11;
            early = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
            for (int i = 0; i < 16; i++) begin
                wrData[i] = $urandom();
                wrStrb[i] = 4'($urandom_range(0, 15));
            end
            applyStimulus($urandom_range(0, 1) == 1, id, addr, len, size, burst, early, -1, 0, 1'b1);
        end

        for (int i = 0; i < 64; i++) checkOutput("final_mem", sram[i], modelMem[i]);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
